// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared constants and the fetch-buffer entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_fifo
// Description : In-order FIFO of fetch entries with flush; full/empty by count.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter  int DEPTH   = 2,
  localparam int c_cnt_w = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_push,
  input  fetch_entry_t       i_push_data,
  input  logic               i_pop,
  output fetch_entry_t       o_head,
  output logic [c_cnt_w-1:0] o_count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  fetch_entry_t       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = i_push & ~i_flush & (r_count != c_cnt_w'(DEPTH));
  assign w_do_pop  = i_pop  & ~i_flush & (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
    end
  end

  // Storage needs no reset: the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rv_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch
// Description : Credit-limited instruction fetch with redirect flush/discard.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RV_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int                 c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

  logic [31:0]        r_pc;
  logic [31:0]        r_addr;
  logic               r_req;
  logic               r_stale;
  logic [c_cnt_w-1:0] r_out;
  logic [c_cnt_w-1:0] r_discard;

  logic               w_gnt;
  logic               w_rvalid;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic               w_rq_push;
  logic               w_credit;
  logic [31:0]        w_pc_n;
  logic [c_cnt_w-1:0] w_out_n;
  logic [c_cnt_w-1:0] w_cnt_n;
  logic [c_cnt_w-1:0] w_discard_n;
  logic [c_cnt_w-1:0] w_fifo_count;
  logic [c_cnt_w-1:0] w_rq_count;
  fetch_entry_t       w_head;
  fetch_entry_t       w_rq_head;
  fetch_entry_t       w_push_entry;
  fetch_entry_t       w_rq_entry;
  logic               w_unused_ok;

  assign w_gnt     = r_req & imem_gnt_i;
  assign w_rvalid  = imem_rvalid_i & (r_out != '0);
  assign w_drop    = w_rvalid & (r_discard != '0);
  assign w_push    = w_rvalid & ~w_drop & ~redirect_i & (w_rq_count != '0);
  assign w_pop     = instr_valid_o & instr_ready_i & ~redirect_i;
  // A grant for a request issued before a redirect never enters the PC queue.
  assign w_rq_push = w_gnt & ~r_stale & ~redirect_i;

  assign w_rq_entry   = '{pc: r_addr, instr: RV_NOP};
  assign w_push_entry = '{pc: w_rq_head.pc, instr: imem_rdata_i};
  assign w_unused_ok  = ^w_rq_head.instr;

  always_comb begin
    w_out_n     = r_out + c_cnt_w'(w_gnt) - c_cnt_w'(w_rvalid);
    w_cnt_n     = redirect_i ? '0 : w_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    w_pc_n      = r_pc;
    w_discard_n = r_discard + c_cnt_w'(w_gnt & r_stale) - c_cnt_w'(w_drop);
    if (redirect_i) begin
      w_pc_n      = {redirect_pc_i[31:2], 2'b00};
      w_discard_n = w_out_n;
    end else if (w_gnt && !r_stale) begin
      w_pc_n = r_pc + 32'd4;
    end
    w_credit = ({1'b0, w_out_n} + {1'b0, w_cnt_n}) < c_depth;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_req     <= 1'b0;
      r_stale   <= 1'b0;
      r_out     <= '0;
      r_discard <= '0;
    end else begin
      r_pc      <= w_pc_n;
      r_out     <= w_out_n;
      r_discard <= w_discard_n;
      if (redirect_i && r_req && !imem_gnt_i) r_stale <= 1'b1;
      else if (w_gnt)                         r_stale <= 1'b0;
      // An ungranted request is held untouched, even across a redirect.
      if (!(r_req && !imem_gnt_i)) begin
        r_req  <= w_credit;
        r_addr <= w_pc_n;
      end
    end
  end

  rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk         (clk),
    .rst         (reset),
    .i_flush     (redirect_i),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count)
  );

  rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_req_pc (
    .clk         (clk),
    .rst         (reset),
    .i_flush     (redirect_i),
    .i_push      (w_rq_push),
    .i_push_data (w_rq_entry),
    .i_pop       (w_push),
    .o_head      (w_rq_head),
    .o_count     (w_rq_count)
  );

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign instr_valid_o = (w_fifo_count != '0);
  assign instr_o       = instr_valid_o ? w_head.instr : RV_NOP;
  assign instr_pc_o    = instr_valid_o ? w_head.pc : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_fetch
// Description : Randomized scoreboard bench for rv_fetch with epoch-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fetch;
  import rv_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  rv_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           epoch = 0;
  int           req_epoch = 0;
  int           delivered = 0;
  logic [31:0]  exp_fetch = RPC;
  logic [31:0]  pend_addr = 32'h0;
  bit           pend = 1'b0;
  bit           first_req = 1'b0;
  bit           in_reset = 1'b1;
  bit           redir_prev = 1'b0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Monitor: compares the presented head against the scoreboard and retires it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset) begin
        if (redir_prev) check1("valid_after_redirect", instr_valid_o, 1'b0);
        if (instr_valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr actual valid=1 pc=%h required valid=0", instr_pc_o);
          end else begin
            check32("instr_pc", instr_pc_o, exp_q[0].pc);
            check32("instr", instr_o, exp_q[0].instr);
            if (instr_ready_i && !redirect_i) begin
              void'(exp_q.pop_front());
              delivered++;
            end
          end
        end else begin
          check32("nop_when_empty", instr_o, RV_NOP);
        end
        redir_prev = redirect_i;
      end else begin
        redir_prev = 1'b0;
      end
    end
  end

  // Driver: one clock of memory/decode/redirect stimulus plus reference-model update.
  task automatic step(input int p_gnt, input int p_rv, input int p_rdy, input int p_rd);
    mreq_t       m;
    logic        rd;
    logic [31:0] tgt;
    @(negedge clk);
    #1;
    cyc++;
    if (first_req) begin
      check1("first_req", imem_req_o, 1'b1);
      first_req = 1'b0;
    end
    if (pend) begin
      check1("req_hold", imem_req_o, 1'b1);
      check32("addr_hold", imem_addr_o, pend_addr);
    end else if (imem_req_o) begin
      check32("req_addr", imem_addr_o, exp_fetch);
      req_epoch = epoch;
    end
    if (imem_req_o) begin
      checks++;
      if (mem_q.size() + exp_q.size() >= DEPTH) begin
        errors++;
        $display("FAIL credit actual=%0d required<%0d", mem_q.size() + exp_q.size(), DEPTH);
      end
    end
    imem_gnt_i    = imem_req_o && ($urandom_range(99) < p_gnt);
    imem_rvalid_i = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rv);
    imem_rdata_i  = imem_rvalid_i ? data_of(mem_q[0].addr) : $urandom;
    instr_ready_i = ($urandom_range(99) < p_rdy);
    rd            = ($urandom_range(99) < p_rd);
    tgt           = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : 32'($urandom_range(1023));
    redirect_i    = rd;
    redirect_pc_i = rd ? tgt : $urandom;
    #2;
    if (imem_rvalid_i) begin
      m = mem_q.pop_front();
      if (m.epoch == epoch && !rd) exp_q.push_back('{pc: m.addr, instr: data_of(m.addr)});
    end
    if (imem_gnt_i) begin
      mem_q.push_back('{addr: imem_addr_o, epoch: req_epoch, due: cyc + 1});
      if (req_epoch == epoch) exp_fetch = imem_addr_o + 32'd4;
    end
    if (rd) begin
      exp_fetch = {tgt[31:2], 2'b00};
      exp_q.delete();
      epoch++;
    end
    pend      = imem_req_o && !imem_gnt_i;
    pend_addr = imem_addr_o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset    = 1'b1;
    in_reset = 1'b1;
    #1;
    check1("rst_req", imem_req_o, 1'b0);
    check32("rst_addr", imem_addr_o, RPC);
    check1("rst_valid", instr_valid_o, 1'b0);
    check32("rst_instr", instr_o, RV_NOP);
    check32("rst_pc", instr_pc_o, 32'h0);
    mem_q.delete();
    exp_q.delete();
    epoch++;
    pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      imem_rvalid_i = i[0];
      imem_gnt_i    = 1'b1;
      imem_rdata_i  = $urandom;
      instr_ready_i = 1'b1;
      redirect_i    = 1'b0;
    end
    check1("rst_hold_req", imem_req_o, 1'b0);
    check1("rst_hold_valid", instr_valid_o, 1'b0);
    @(negedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b0;
    reset         = 1'b0;
    in_reset      = 1'b0;
    exp_fetch     = RPC;
    first_req     = 1'b1;
  endtask

  initial begin
    do_reset();
    repeat (40) step(100, 100, 100, 0);
    repeat (12) step(100, 100, 0, 0);
    check1("stall_no_req", imem_req_o, 1'b0);
    repeat (20) step(100, 100, 100, 0);
    repeat (1500) step(70, 60, 70, 6);
    for (int i = 0; i < 20 && mem_q.size() < DEPTH; i++) step(100, 0, 100, 0);
    do_reset();
    repeat (1500) step(40, 50, 60, 15);
    repeat (60) step(100, 100, 100, 0);
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL progress actual=%0d required>=100", delivered);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
